// File: rtl/ddr_port_arbiter_if.sv
// ddr_port_arbiter_if: pipelined Avalon-MM read/write port bundle
interface ddr_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 16);
  logic [ADDR_W-1:0] addr;
  logic read;
  logic write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic readdatavalid;
  logic waitrequest;
  modport master (output addr, read, write, writedata, input readdata, readdatavalid, waitrequest);
  modport slave (input addr, read, write, writedata, output readdata, readdatavalid, waitrequest);
endinterface

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: round-robin share of one DDR Avalon-MM port between a read and a write requester
module ddr_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 16,
  parameter int MAX_HOLD    = 16,
  parameter int MAX_PENDING = 8,
  parameter int PEND_W      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  ddr_port_arbiter_if.slave         rd,
  ddr_port_arbiter_if.slave         wr,
  ddr_port_arbiter_if.master        ddr,
  output logic [1:0]                gnt,
  output logic [PEND_W-1:0]         rd_pending
);
  typedef enum logic [1:0] {IDLE = 2'b00, GNT_RD = 2'b01, GNT_WR = 2'b10} state_t;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic OWN_RD = 1'b0;
  localparam logic OWN_WR = 1'b1;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [ADDR_W-1:0] addr_sel;
  logic pend_full, rd_acc, xfer, own_req, other_req;
  always_comb begin
    pend_full = pend_q == PEND_W'(MAX_PENDING);
    addr_sel = state_q == GNT_WR ? wr.addr : rd.addr;
    ddr.read = !rst && state_q == GNT_RD && rd.read && !pend_full;
    ddr.write = !rst && state_q == GNT_WR && wr.write;
    rd.waitrequest = rst || state_q != GNT_RD || ddr.waitrequest || pend_full;
    wr.waitrequest = rst || state_q != GNT_WR || ddr.waitrequest;
    rd_acc = ddr.read && !ddr.waitrequest;
    xfer = (ddr.read || ddr.write) && !ddr.waitrequest;
    // hold count saturates so an uncontested grant can run indefinitely
    hold_inc = xfer && hold_q != HOLD_W'(MAX_HOLD) ? hold_q + 1'b1 : hold_q;
    own_req = state_q == GNT_WR ? wr.write : rd.read;
    other_req = state_q == GNT_WR ? rd.read : wr.write;
    pend_d = rd_acc && !ddr.readdatavalid ? pend_q + 1'b1 :
             !rd_acc && ddr.readdatavalid && pend_q != '0 ? pend_q - 1'b1 : pend_q;
    state_d = state_q;
    last_d = last_q;
    hold_d = hold_inc;
    if (state_q == IDLE) begin
      hold_d = '0;
      if (rd.read && (!wr.write || last_q == OWN_WR)) begin
        state_d = GNT_RD;
        last_d = OWN_RD;
      end else if (wr.write) begin
        state_d = GNT_WR;
        last_d = OWN_WR;
      end
    end else if (!own_req || (other_req && hold_inc == HOLD_W'(MAX_HOLD))) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= OWN_WR;
      hold_q <= '0;
      pend_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      hold_q <= hold_d;
      pend_q <= pend_d;
    end
  end
  assign ddr.addr = addr_sel;
  assign ddr.writedata = wr.writedata;
  assign rd.readdata = ddr.readdata;
  assign rd.readdatavalid = ddr.readdatavalid;
  assign wr.readdata = {DATA_W{1'b0}};
  assign wr.readdatavalid = 1'b0;
  assign gnt = state_q;
  assign rd_pending = pend_q;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter: directed checks of arbitration, read throttling and reset behaviour
module tb_ddr_port_arbiter;
  logic clk, rst;
  logic [1:0] gnt;
  logic [3:0] rd_pending;
  ddr_port_arbiter_if #(.ADDR_W(32), .DATA_W(16)) rd_if();
  ddr_port_arbiter_if #(.ADDR_W(32), .DATA_W(16)) wr_if();
  ddr_port_arbiter_if #(.ADDR_W(32), .DATA_W(16)) ddr_if();
  ddr_port_arbiter #(.ADDR_W(32), .DATA_W(16), .MAX_HOLD(16), .MAX_PENDING(8), .PEND_W(4)) dut (
    .clk(clk), .rst(rst), .rd(rd_if), .wr(wr_if), .ddr(ddr_if), .gnt(gnt), .rd_pending(rd_pending)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {int due; logic [15:0] d;} rsp_t;
  rsp_t ddrq[$];
  logic [15:0] rexp[$];
  int run_own[$], run_len[$];
  int n_chk, n_pass, cyc, lat, ws, we;
  int rd_sent, rd_total, wr_sent, wr_total, n_rd, n_wr, n_rv, pk;
  int cur_own, cur_len, gap, max_gap, bad;
  bit rv_stall, track;
  logic [31:0] rd_base, wr_base, exp_rd_addr, exp_wr_addr;
  function automatic logic [15:0] rdat(logic [31:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction
  function automatic logic [15:0] wdat(int i);
    return 16'(i * 7 + 32'h8001);
  endfunction
  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask
  task automatic tick();
    logic a_rd, a_wr, d_rd, d_wr;
    rsp_t r;
    #2;
    a_rd = rd_if.read && !rd_if.waitrequest;
    a_wr = wr_if.write && !wr_if.waitrequest;
    d_rd = ddr_if.read && !ddr_if.waitrequest;
    d_wr = ddr_if.write && !ddr_if.waitrequest;
    if (d_rd) begin
      chk("rd_addr", ddr_if.addr, exp_rd_addr);
      r.due = cyc + lat;
      r.d = rdat(ddr_if.addr);
      ddrq.push_back(r);
      rexp.push_back(rdat(exp_rd_addr));
      exp_rd_addr++;
      n_rd++;
    end
    if (d_wr) begin
      chk("wr_addr", ddr_if.addr, exp_wr_addr);
      chk("wr_data", {16'h0, ddr_if.writedata}, {16'h0, wdat(n_wr)});
      exp_wr_addr++;
      n_wr++;
    end
    if (rd_if.readdatavalid) begin
      n_rv++;
      if (rexp.size() == 0) chk("rv_spurious", rd_if.readdatavalid, 0);
      else chk("rv_data", {16'h0, rd_if.readdata}, {16'h0, rexp.pop_front()});
    end
    if (int'(rd_pending) > pk) pk = int'(rd_pending);
    if (track) begin
      if (gnt == 2'b00) begin
        if (cur_len > 0) begin
          run_own.push_back(cur_own);
          run_len.push_back(cur_len);
          cur_len = 0;
        end
        gap++;
      end else begin
        if (run_len.size() > 0 && gap > max_gap) max_gap = gap;
        gap = 0;
        cur_own = int'(gnt);
        cur_len += int'(d_rd || d_wr);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (a_rd) begin
      rd_sent++;
      rd_if.addr = rd_base + rd_sent;
      rd_if.read = rd_sent < rd_total;
    end
    if (a_wr) begin
      wr_sent++;
      wr_if.addr = wr_base + wr_sent;
      wr_if.writedata = wdat(wr_sent);
      wr_if.write = wr_sent < wr_total;
    end
    ddr_if.readdatavalid = 1'b0;
    if (ddrq.size() > 0 && ddrq[0].due <= cyc && !rv_stall) begin
      r = ddrq.pop_front();
      ddr_if.readdatavalid = 1'b1;
      ddr_if.readdata = r.d;
    end
    ddr_if.waitrequest = cyc >= ws && cyc < we;
    #1;
  endtask
  task automatic start_test(int l, logic [31:0] rb, logic [31:0] wb);
    rst = 1'b1;
    rd_if.read = 1'b0;
    wr_if.write = 1'b0;
    rv_stall = 1'b0;
    ws = -1;
    we = -1;
    lat = l;
    track = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    rd_base = rb;
    wr_base = wb;
    exp_rd_addr = rb;
    exp_wr_addr = wb;
    rd_if.addr = rb;
    wr_if.addr = wb;
    wr_if.writedata = wdat(0);
    rd_sent = 0; wr_sent = 0; rd_total = 0; wr_total = 0;
    n_rd = 0; n_wr = 0; n_rv = 0; pk = 0;
    cur_len = 0; gap = 0; max_gap = 0;
    run_own.delete();
    run_len.delete();
    #1;
  endtask
  task automatic drain(int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (rd_sent >= rd_total && wr_sent >= wr_total && ddrq.size() == 0 && rexp.size() == 0) break;
      tick();
    end
    if (cur_len > 0) begin
      run_own.push_back(cur_own);
      run_len.push_back(cur_len);
      cur_len = 0;
    end
  endtask
  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    rst = 1'b1;
    rd_if.addr = '0; rd_if.read = 1'b0; rd_if.write = 1'b0; rd_if.writedata = '0;
    wr_if.addr = '0; wr_if.write = 1'b0; wr_if.read = 1'b0; wr_if.writedata = '0;
    ddr_if.readdata = '0; ddr_if.readdatavalid = 1'b0; ddr_if.waitrequest = 1'b0;
    start_test(3, 32'h0, 32'h8000);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_pend", rd_pending, 0);
    chk("rst_ddr_read", ddr_if.read, 0);
    chk("rst_ddr_write", ddr_if.write, 0);
    chk("rst_rd_wait", rd_if.waitrequest, 1);
    chk("rst_wr_wait", wr_if.waitrequest, 1);
    // read only, latency 3
    rd_total = 256;
    rd_if.read = 1'b1;
    tick();
    chk("t1_gnt", gnt, 2'b01);
    drain(2000);
    chk("t1_reads", n_rd, 256);
    chk("t1_valids", n_rv, 256);
    chk("t1_peak", pk, 3);
    chk("t1_pend_end", rd_pending, 0);
    chk("t1_gnt_end", gnt, 2'b00);
    // contention: alternating 16-transfer grants, read first
    start_test(3, 32'h1000, 32'h2000);
    rd_total = 256; wr_total = 256; track = 1'b1;
    rd_if.read = 1'b1;
    wr_if.write = 1'b1;
    drain(4000);
    chk("t2_reads", n_rd, 256);
    chk("t2_writes", n_wr, 256);
    chk("t2_valids", n_rv, 256);
    chk("t2_runs", run_len.size(), 32);
    bad = 0;
    foreach (run_len[i]) if (run_len[i] != 16 || run_own[i] != ((i % 2) ? 2 : 1)) bad++;
    chk("t2_bad_runs", bad, 0);
    chk("t2_max_gap", max_gap, 1);
    // throttle at 8 outstanding reads
    start_test(3, 32'h3000, 32'h0);
    rd_total = 20; rv_stall = 1'b1;
    rd_if.read = 1'b1;
    repeat (20) tick();
    chk("t3_reads_held", n_rd, 8);
    chk("t3_pend_full", rd_pending, 8);
    chk("t3_rd_wait", rd_if.waitrequest, 1);
    chk("t3_ddr_read_off", ddr_if.read, 0);
    rv_stall = 1'b0;
    tick();
    chk("t3_first_valid", rd_if.readdatavalid, 1);
    chk("t3_still_full", ddr_if.read, 0);
    tick();
    chk("t3_pend_7", rd_pending, 7);
    chk("t3_read_resume", ddr_if.read, 1);
    drain(2000);
    chk("t3_reads", n_rd, 20);
    chk("t3_valids", n_rv, 20);
    chk("t3_peak", pk, 8);
    // DDR waitrequest during a write burst
    start_test(3, 32'h5000, 32'h6000);
    wr_total = 40; rd_total = 8; track = 1'b1;
    wr_if.write = 1'b1;
    tick();
    chk("t4_gnt", gnt, 2'b10);
    tick();
    tick();
    rd_if.read = 1'b1;
    ws = cyc + 1;
    we = cyc + 6;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_wr_wait", wr_if.waitrequest, 1);
      chk("t4_stall_addr", ddr_if.addr, 32'h6003);
      chk("t4_stall_data", {16'h0, ddr_if.writedata}, {16'h0, wdat(3)});
      chk("t4_stall_gnt", gnt, 2'b10);
      tick();
    end
    chk("t4_wr_wait_off", wr_if.waitrequest, 0);
    drain(2000);
    chk("t4_writes", n_wr, 40);
    chk("t4_reads", n_rd, 8);
    if (run_len.size() > 0) begin
      chk("t4_run0_own", run_own[0], 2);
      chk("t4_run0_len", run_len[0], 16);
    end else chk("t4_runs", run_len.size(), 3);
    // simultaneous accept and valid at pend 4
    start_test(4, 32'h7000, 32'h0);
    rd_total = 12;
    rd_if.read = 1'b1;
    repeat (5) tick();
    chk("t5_pend4", rd_pending, 4);
    chk("t5_valid", rd_if.readdatavalid, 1);
    chk("t5_accept", ddr_if.read, 1);
    tick();
    chk("t5_pend_same", rd_pending, 4);
    drain(500);
    chk("t5_valids", n_rv, 12);
    chk("t5_pend_end", rd_pending, 0);
    // reset with 3 reads outstanding
    start_test(3, 32'h9000, 32'h0);
    rd_total = 64;
    rd_if.read = 1'b1;
    repeat (6) tick();
    chk("t6_pend3", rd_pending, 3);
    rst = 1'b1;
    #1;
    chk("t6_ddr_read_rst", ddr_if.read, 0);
    chk("t6_rd_wait_rst", rd_if.waitrequest, 1);
    n_rv = 0;
    tick();
    rst = 1'b0;
    rd_if.read = 1'b0;
    #1;
    chk("t6_gnt", gnt, 2'b00);
    chk("t6_pend0", rd_pending, 0);
    repeat (4) begin
      tick();
      chk("t6_pend_stay0", rd_pending, 0);
    end
    chk("t6_late_valids", n_rv, 3);
    chk("t6_queue_empty", rexp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ddr_port_arbiter.md
Name: ddr_port_arbiter

Overview:
Shares one DDR3 Avalon-MM slave port between the read_master stream source and the write_master stream sink, replacing the ad-hoc OR of waitrequests. Round-robin arbitration with a bounded hold per grant. Tracks outstanding pipelined reads and throttles the read side at a configurable depth. Read data returns to the read requester only; the write requester never reads.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 16, data width (signed samples, passed unmodified)
MAX_HOLD, 16, max accepted transfers per grant when the other side is requesting (>=1)
MAX_PENDING, 8, max outstanding reads (>=1)
PEND_W, 4, width of the pending-read counter; must hold MAX_PENDING

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rd_addr  in  ADDR_W  read requester address
rd_read  in  1  read requester read strobe
rd_readdata  out  DATA_W  read data to read requester
rd_readdatavalid  out  1  read data valid
rd_waitrequest  out  1  stall to read requester
wr_addr  in  ADDR_W  write requester address
wr_write  in  1  write requester write strobe
wr_writedata  in  DATA_W  write requester data
wr_waitrequest  out  1  stall to write requester
ddr_addr  out  ADDR_W  to DDR slave
ddr_read  out  1  to DDR slave
ddr_write  out  1  to DDR slave
ddr_writedata  out  DATA_W  to DDR slave
ddr_readdata  in  DATA_W  from DDR slave
ddr_readdatavalid  in  1  from DDR slave
ddr_waitrequest  in  1  from DDR slave
gnt  out  2  status: 00 idle, 01 read owner, 10 write owner
rd_pending  out  PEND_W  outstanding read count

Behaviour:
- Registered state: IDLE, GNT_RD, GNT_WR. Also last_owner (1 bit), hold_cnt, pend_cnt. gnt mirrors the state.
- Reset: state IDLE; last_owner = WR, so read wins the first tie; hold_cnt=0; pend_cnt=0.
- Outputs are combinational from state:
  - IDLE: ddr_read=0, ddr_write=0, both waitrequests=1. These are also the reset values.
  - GNT_RD: ddr_addr=rd_addr; ddr_read=rd_read && !pend_full; rd_waitrequest=ddr_waitrequest || pend_full; wr_waitrequest=1.
  - GNT_WR: ddr_addr=wr_addr, ddr_writedata=wr_writedata, ddr_write=wr_write; wr_waitrequest=ddr_waitrequest; rd_waitrequest=1.
  - ddr_addr/ddr_writedata in IDLE: pass rd_addr/wr_writedata (don't-care).
- pend_full = (pend_cnt == MAX_PENDING).
- An accepted transfer is (ddr_read||ddr_write) && !ddr_waitrequest.
- rd_readdata = ddr_readdata and rd_readdatavalid = ddr_readdatavalid, passed through in all states, including read data arriving after a switch to GNT_WR.
- pend_cnt update:
  - +1 on an accepted read; -1 on ddr_readdatavalid.
  - Both in the same cycle: unchanged.
  - Decrement saturates at 0, covering in-flight data after a mid-operation reset.
- IDLE arbitration:
  - Only one side requesting: grant it at the next edge.
  - Both requesting: grant the side != last_owner.
  - Earliest transfer is in the cycle after the request is first seen in IDLE (one bubble).
- On entering GNT_x: hold_cnt=0, last_owner=x. Each accepted transfer increments hold_cnt.
- GNT_x exits to IDLE at the clock edge when either:
  - x's strobe is low, or
  - the other side is requesting and hold_cnt reaches MAX_HOLD, counting the transfer accepted in that cycle.
- An Avalon request held under waitrequest is never dropped: a requester losing its grant keeps its strobe asserted and is served later.
- GNT_RD never waits for pend_cnt==0 before switching. Reads are pipelined; writes are independent.
- rst mid-operation: returns to IDLE next edge. DDR strobes deassert immediately.

Test Plan:
- Read only: rd_read held for 256 addresses 0..255, DDR latency 3, no waitrequest -> gnt=01 after 1 cycle; 256 accepted reads; 256 rd_readdatavalid returned in order; rd_pending peaks at 3 and ends at 0.
- Contention: both requesting continuously, MAX_HOLD=16 -> alternating grants of exactly 16 transfers, read first, each separated by 1 IDLE cycle; no transfer lost or duplicated (count 256 each).
- Throttle: DDR readdatavalid held off 20 cycles, MAX_PENDING=8 -> exactly 8 reads accepted, then rd_waitrequest=1 and ddr_read=0 until the first valid, then one more read accepted per valid.
- DDR waitrequest: ddr_waitrequest pulsed high 5 cycles mid-write burst -> wr_waitrequest follows it; wr_addr/wr_writedata held stable; hold_cnt does not advance during the stall.
- Simultaneous accept and valid in the same cycle at pend_cnt=4 -> pend_cnt stays 4.
- Reset mid-burst with 3 reads outstanding -> gnt=00 next cycle, pend_cnt=0; the 3 late readdatavalid still reach rd_readdatavalid; pend_cnt stays 0.
